// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES key schedule, one 48-bit subkey per handshake.
//   clk, rst_n        : clock, synchronous active-low reset
//   key_in, decrypt   : 64-bit key (DES bit 1 = key_in[63]) and mode, taken with key_valid
//   key_valid/ready   : key load handshake (ready only while idle)
//   subkey, round_idx : current PC-2 subkey and its 0..15 emission position
//   subkey_valid/last : subkey present / this is the 16th subkey
//   subkey_ready      : consumer takes the current subkey
//   key_err           : odd-parity violation on the last loaded key (PARITY_CHECK=1)
module des_key_schedule #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        subkey_valid,
    output logic        subkey_last,
    input  logic        subkey_ready,
    output logic        key_err
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Table entries are 1-based DES bit numbers counted from the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return r;
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] x, input logic right, input logic two);
        return right ? (two ? {x[1:0], x[27:2]} : {x[0], x[27:1]})
                     : (two ? {x[25:0], x[27:26]} : {x[26:0], x[27]});
    endfunction

    function automatic logic even_byte(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) bad |= ~^k[6'(8 * b) +: 8];
        return bad;
    endfunction

    state_t      state_q, state_d;
    logic [55:0] cd_q, cd_d, pc1_key;
    logic        dec_q, dec_d;
    logic [3:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic        load, adv, two;
    logic [4:0]  n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cd_q    <= '0;
            dec_q   <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        load    = state_q == IDLE && key_valid;
        adv     = state_q == RUN && subkey_ready;
        state_d = load ? RUN : (adv && idx_q == 4'd15) ? IDLE : state_q;
    end

    // n is the DES shift-schedule number (1..16) used for the step leaving round idx_q;
    // only rounds 1, 2, 9 and 16 shift by one.
    always_comb begin
        n       = dec_q ? 5'd16 - {1'b0, idx_q} : {1'b0, idx_q} + 5'd2;
        two     = !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
        pc1_key = pc1(key_in);
        cd_d    = cd_q;
        dec_d   = dec_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (load) begin
            // Decrypt starts from C0/D0, which equals C16/D16 after the full 28-bit rotation.
            cd_d  = decrypt ? pc1_key : {rot(pc1_key[55:28], 1'b0, 1'b0), rot(pc1_key[27:0], 1'b0, 1'b0)};
            dec_d = decrypt;
            idx_d = '0;
            err_d = PARITY_CHECK && even_byte(key_in);
        end else if (adv) begin
            cd_d  = {rot(cd_q[55:28], dec_q, two), rot(cd_q[27:0], dec_q, two)};
            idx_d = idx_q + 4'd1;
        end
    end

    always_comb begin
        key_ready    = state_q == IDLE;
        subkey_valid = state_q == RUN;
        subkey_last  = state_q == RUN && idx_q == 4'd15;
        subkey       = pc2(cd_q);
        round_idx    = idx_q;
        key_err      = err_q;
    end
endmodule
